// File: rtl/gf_inst_fetch_if.sv
// Fetch-stage bus: PC-generator feedback, instruction-memory req/gnt/rvalid and decode handshake.
// master = fetch block, slave = environment (PC generator, memory, decode).
interface gf_inst_fetch_if #(
   parameter int ADDR_LEN = 64,
   parameter int INST_LEN = 32
);
   logic [ADDR_LEN-1:0] i_pc;
   logic                i_sig_flush;
   logic [ADDR_LEN-1:0] o_last_pc;
   logic                o_mem_req;
   logic [ADDR_LEN-1:0] o_mem_addr;
   logic                i_mem_gnt;
   logic                i_mem_rvalid;
   logic [INST_LEN-1:0] i_mem_rdata;
   logic                o_inst_valid;
   logic [INST_LEN-1:0] o_inst;
   logic [ADDR_LEN-1:0] o_inst_pc;
   logic                i_dec_ready;
   logic                o_sig_misalign;

   modport master (
      input  i_pc, i_sig_flush, i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_dec_ready,
      output o_last_pc, o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc, o_sig_misalign
   );

   modport slave (
      output i_pc, i_sig_flush, i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_dec_ready,
      input  o_last_pc, o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc, o_sig_misalign
   );
endinterface

// File: rtl/gf_inst_fetch.sv
// Instruction fetch: credit-limited memory requests, in-order PC tags, registered decode FIFO.
// Response-to-decode latency 1 cycle; memory is never backpressured, decode stalls hold the head.
module gf_inst_fetch #(
   parameter int ADDR_LEN   = 64,
   parameter int INST_LEN   = 32,
   parameter int INST_BLEN  = 4,
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_OUTST  = 2
) (
   input logic              clk,
   input logic              i_sig_rst_n,
   gf_inst_fetch_if.master  bus
);
   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam logic [ADDR_LEN-1:0] STRIDE = ADDR_LEN'(INST_BLEN);

   logic [OW-1:0]       r_outst, r_drop, w_outst_nxt;
   logic [CW-1:0]       r_cnt;
   logic [PW-1:0]       r_wp, r_rp;
   logic [TW-1:0]       r_twp, r_trp;
   logic                r_misalign;
   logic [ADDR_LEN-1:0] r_tag      [MAX_OUTST];
   logic [ADDR_LEN-1:0] r_fifo_pc  [FIFO_DEPTH];
   logic [INST_LEN-1:0] r_fifo_ins [FIFO_DEPTH];

   logic w_aligned, w_credit, w_req, w_gnt, w_rsp, w_keep, w_pop, w_flush;

   function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
      return (p == TW'(MAX_OUTST - 1)) ? '0 : p + TW'(1);
   endfunction

   assign w_flush     = bus.i_sig_flush;
   assign w_aligned   = ((bus.i_pc & (STRIDE - ADDR_LEN'(1))) == '0);
   // Buffered plus in-flight never exceeds FIFO_DEPTH, so every response has a slot.
   assign w_credit    = (int'(r_outst) < MAX_OUTST) && ((int'(r_cnt) + int'(r_outst)) < FIFO_DEPTH);
   assign w_req       = w_credit & ~w_flush & w_aligned;
   assign w_gnt       = w_req & bus.i_mem_gnt;
   // A response with nothing outstanding is stale (e.g. across reset) and is ignored.
   assign w_rsp       = bus.i_mem_rvalid & (r_outst != '0);
   assign w_keep      = w_rsp & ~w_flush & (r_drop == '0);
   assign w_pop       = (r_cnt != '0) & bus.i_dec_ready & ~w_flush;
   assign w_outst_nxt = r_outst + OW'(w_gnt) - OW'(w_rsp);

   assign bus.o_mem_req      = w_req;
   assign bus.o_mem_addr     = bus.i_pc;
   assign bus.o_last_pc      = w_gnt ? bus.i_pc : bus.i_pc - STRIDE;
   assign bus.o_inst_valid   = (r_cnt != '0);
   assign bus.o_inst         = r_fifo_ins[r_rp];
   assign bus.o_inst_pc      = r_fifo_pc[r_rp];
   assign bus.o_sig_misalign = r_misalign;

   always_ff @(posedge clk or negedge i_sig_rst_n) begin
      if (!i_sig_rst_n) begin
         r_outst    <= '0;
         r_drop     <= '0;
         r_cnt      <= '0;
         r_wp       <= '0;
         r_rp       <= '0;
         r_twp      <= '0;
         r_trp      <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_outst    <= w_outst_nxt;
         r_misalign <= ~w_aligned & ~w_flush;
         if (w_gnt) r_twp <= tag_next(r_twp);
         if (w_rsp) r_trp <= tag_next(r_trp);
         if (w_flush) begin
            // Everything still in flight after this edge belongs to the old stream.
            r_drop <= w_outst_nxt;
            r_cnt  <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
         end else begin
            if (w_rsp && (r_drop != '0)) r_drop <= r_drop - OW'(1);
            if (w_keep) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            r_cnt <= r_cnt + CW'(w_keep) - CW'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_gnt) r_tag[r_twp] <= bus.i_pc;
      if (w_keep) begin
         r_fifo_pc[r_wp]  <= r_tag[r_trp];
         r_fifo_ins[r_wp] <= bus.i_mem_rdata;
      end
   end
endmodule

// File: tb/tb_gf_inst_fetch.sv
// Directed bench for gf_inst_fetch with a PC-generator/memory model and in-order scoreboard.
module tb_gf_inst_fetch;
   typedef struct {
      logic [63:0] pc;
      logic [31:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gf_inst_fetch_if #(.ADDR_LEN(64), .INST_LEN(32)) bus ();
   gf_inst_fetch dut (.clk(clk), .i_sig_rst_n(rst_n), .bus(bus));

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] pc, tgt;
   bit          gnt_en, rdy, fl, rsp_en, chk_first;
   int          m_outst, m_cnt, m_drop;
   bit          exp_mis;
   bit          p_hold;
   logic [63:0] p_pc;
   logic [31:0] p_inst;
   logic [63:0] mem_q[$];
   ent_t        exp_q[$];

   function automatic logic [31:0] mdat(input logic [63:0] a);
      return {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      bit          al, exp_req, g, pop, rsp;
      logic [63:0] lp;
      ent_t        e;
      bus.i_pc        = pc;
      bus.i_sig_flush = fl;
      bus.i_mem_gnt   = gnt_en;
      bus.i_dec_ready = rdy;
      @(negedge clk);
      al      = (pc[1:0] == 2'b00);
      exp_req = (m_outst < 2) && (m_cnt + m_outst < 2) && !fl && al;
      g       = exp_req && gnt_en;
      lp      = g ? pc : pc - 64'd4;
      chk("mem_req", bus.o_mem_req, exp_req);
      chk("mem_addr", bus.o_mem_addr, pc);
      chk("last_pc", bus.o_last_pc, lp);
      chk("inst_valid", bus.o_inst_valid, m_cnt > 0);
      chk("misalign", bus.o_sig_misalign, exp_mis);
      if (p_hold) begin
         chk("hold_pc", bus.o_inst_pc, p_pc);
         chk("hold_inst", bus.o_inst, p_inst);
      end
      pop = (m_cnt > 0) && rdy && !fl;
      if (pop) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("inst_pc", bus.o_inst_pc, e.pc);
            chk("inst", bus.o_inst, e.d);
            if (chk_first) chk("first_after_flush", bus.o_inst_pc, tgt);
            chk_first = 0;
         end
      end
      p_hold = (m_cnt > 0) && !rdy && !fl;
      p_pc   = bus.o_inst_pc;
      p_inst = bus.o_inst;
      rsp = bus.i_mem_rvalid && (m_outst > 0);
      if (rsp) m_outst--;
      if (fl) begin
         m_drop = m_outst;
         m_cnt  = 0;
         exp_q.delete();
      end else begin
         if (rsp) begin
            if (m_drop > 0) m_drop--;
            else m_cnt++;
         end
         if (pop) m_cnt--;
      end
      if (g) begin
         m_outst++;
         exp_q.push_back('{pc: pc, d: mdat(pc)});
         mem_q.push_back(pc);
      end
      exp_mis = !al && !fl;
      pc = fl ? tgt : lp + 64'd4;
      @(posedge clk);
      #1;
      if (rsp_en && mem_q.size() > 0) begin
         bus.i_mem_rvalid = 1'b1;
         bus.i_mem_rdata  = mdat(mem_q.pop_front());
      end else begin
         bus.i_mem_rvalid = 1'b0;
         bus.i_mem_rdata  = '0;
      end
   endtask

   task automatic model_reset();
      m_outst = 0; m_cnt = 0; m_drop = 0;
      exp_mis = 0; p_hold = 0; chk_first = 0;
      exp_q.delete();
   endtask

   initial begin
      pc = 64'h0; tgt = 64'h0;
      gnt_en = 0; rdy = 1; fl = 0; rsp_en = 1;
      model_reset();
      bus.i_pc = pc; bus.i_sig_flush = 0; bus.i_mem_gnt = 0;
      bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0; bus.i_dec_ready = 1;

      // Reset state: outputs from an empty block at PC 0.
      #1;
      chk("rst_inst_valid", bus.o_inst_valid, 1'b0);
      chk("rst_misalign", bus.o_sig_misalign, 1'b0);
      chk("rst_mem_req", bus.o_mem_req, 1'b1);
      chk("rst_last_pc", bus.o_last_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Streaming from PC 0.
      gnt_en = 1;
      repeat (12) cyc();

      // Grant stall at 0x100.
      fl = 1; tgt = 64'h100; cyc(); fl = 0;
      gnt_en = 0;
      repeat (3) cyc();
      gnt_en = 1;
      repeat (5) cyc();

      // Decode backpressure: fill, hold, drain.
      rdy = 0;
      repeat (6) cyc();
      rdy = 1;
      repeat (6) cyc();

      // Two in flight, then redirect to 0x400.
      rsp_en = 0;
      repeat (3) cyc();
      fl = 1; tgt = 64'h400; chk_first = 1; rsp_en = 1; cyc(); fl = 0;
      repeat (10) cyc();

      // Misaligned PC persists until redirected.
      fl = 1; tgt = 64'h102; cyc(); fl = 0;
      repeat (3) cyc();
      fl = 1; tgt = 64'h200; cyc(); fl = 0;
      repeat (6) cyc();

      // Reset with requests in flight and a buffered entry.
      rdy = 0; rsp_en = 0;
      repeat (3) cyc();
      rsp_en = 1; cyc();
      rsp_en = 0; cyc();
      rst_n = 1'b0;
      #1;
      chk("midrst_inst_valid", bus.o_inst_valid, 1'b0);
      chk("midrst_misalign", bus.o_sig_misalign, 1'b0);
      model_reset();
      bus.i_mem_rvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      pc = 64'h800; rdy = 1; rsp_en = 1; gnt_en = 0;
      repeat (4) cyc();
      gnt_en = 1;
      repeat (10) cyc();
      chk("final_outst_empty", 64'(mem_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
